fb_line_fetch_arbiter: RTL and testbench
========================================

Name: fb_line_fetch_arbiter

Overview:
- Schedules the single-port framebuffer memory behind the 800x480 display pipeline.
- During each display line it prefetches the next visible line into one half of a ping-pong line buffer, while the display reads the other half.
- Leftover memory slots go to one drawing-engine write port. A fairness rule bounds write latency during fetch.
- Sits between the VGA timing generator (LINE_START/LINE_NUM), the framebuffer RAM and the line buffer.

Parameters:
H_ACTIVE 800 visible pixels per line = reads per fetch
V_ACTIVE 480 visible lines
V_TOTAL 528 total lines per frame
ADDR_W 19 framebuffer word address width
DATA_W 3 pixel width (R,G,B), one pixel per memory word
FAIR_N 8 max consecutive fetch reads while a write is pending

Ports:
CLOCK_PIXEL input 1 pixel clock, all logic rising-edge
RESET_N input 1 asynchronous active-low reset
LINE_START input 1 one-cycle pulse at start of each line (hor count 0)
LINE_NUM input 10 line beginning now, 0..V_TOTAL-1, valid with LINE_START
WR_REQ input 1 write request, held with WR_ADDR/WR_DATA until WR_ACK
WR_ADDR input ADDR_W write address
WR_DATA input DATA_W write data
WR_ACK output 1 one-cycle grant, high in the same cycle the write command is on MEM_*
MEM_EN output 1 memory command valid
MEM_WE output 1 1=write, 0=read
MEM_ADDR output ADDR_W memory address
MEM_WDATA output DATA_W memory write data
MEM_RDATA input DATA_W read data, valid exactly 1 cycle after read command
LB_WE output 1 line-buffer write strobe
LB_ADDR output 11 {bank, x[9:0]}
LB_DATA output DATA_W line-buffer write data
DISP_BANK output 1 bank the display reads
FETCH_BUSY output 1 fetch in progress
UNDERRUN output 1 sticky: line started before previous fetch finished
CLR_UNDERRUN input 1 synchronous clear of UNDERRUN

Behaviour:
- Reset, asynchronous: all outputs 0, DISP_BANK=0, internal fill bank=1, state IDLE, x counter 0. Reset mid-fetch aborts it; no LB_WE after reset is asserted.
- All MEM_*, WR_ACK and LB_* outputs are registered. A slot decision in cycle t appears on the outputs in cycle t+1.
- Fetch target on LINE_START:
  - LINE_NUM+1 < V_ACTIVE: fetch LINE_NUM+1.
  - LINE_NUM == V_TOTAL-1: fetch line 0.
  - Otherwise: no fetch.
- Bank swap on every LINE_START: DISP_BANK <= fill bank, then fill bank <= new ~DISP_BANK. The swap happens even on non-fetch lines only if a fetch completed since the last swap; otherwise DISP_BANK is held.
- States:
  - IDLE: every slot is offered to the writer.
  - FETCH: x runs 0..H_ACTIVE-1.
  - IDLE->FETCH on a LINE_START with a target.
  - FETCH->IDLE after the read with x=H_ACTIVE-1 is issued.
- Read address = target_line*H_ACTIVE + x. Computed via constant multiply or incremental base; must be exact. Max address 383999 fits ADDR_W.
- Slot priority in FETCH: read, except a write is granted when WR_REQ=1, WR_ACK=0, and FAIR_N reads have issued since the last write or the fetch start. x advances only on an issued read.
- In IDLE, a write is granted when WR_REQ=1 and WR_ACK=0. No back-to-back writes: max write rate is 1 per 2 cycles.
- Read return path: one cycle after the read command, LB_WE=1, LB_ADDR={fill bank, x of that read}, LB_DATA=MEM_RDATA.
- FETCH_BUSY=1 from the first read command through the final LB_WE cycle.
- Fetch time is at most H_ACTIVE + H_ACTIVE/FAIR_N + 1 = 901 cycles, which is less than the 976-cycle line.
- LINE_START while FETCH_BUSY:
  - Set UNDERRUN.
  - Drop the in-flight fetch, except a return already pending still writes its LB entry.
  - Swap banks anyway.
  - Start the new target fetch at x=0 on the next slot.
- CLR_UNDERRUN and a simultaneous underrun event in the same cycle: set wins.
- LINE_START and a writer grant decision in the same cycle: the write that cycle is honoured; the fetch starts on the following slot.

Test Plan:
- Reset, then LINE_START with LINE_NUM=5, WR_REQ=0 -> 800 consecutive reads at MEM_ADDR 4800..5599; LB_WE one cycle later with LB_ADDR=1024+0..1024+799; FETCH_BUSY deasserts; next LINE_START sets DISP_BANK=1.
- Same fetch with WR_REQ held high and acking new addresses -> repeating pattern of 8 reads then 1 write; exactly 100 WR_ACK pulses during the fetch; fetch done within 901 cycles; no read address skipped or duplicated.
- LINE_NUM=527 -> fetch of line 0 at addresses 0..799. LINE_NUM=479 or 500 -> no reads, and WR_ACK alternates every other cycle under continuous WR_REQ.
- LINE_START 500 cycles into a fetch -> UNDERRUN=1, reads restart at the new line base with x=0, DISP_BANK toggles. CLR_UNDERRUN pulse -> UNDERRUN=0.
- RESET_N low 300 cycles into a fetch -> all outputs 0 asynchronously; after release, no LB_WE or MEM_EN until the next LINE_START or WR_REQ.
- WR_REQ and LINE_START in the same IDLE cycle -> WR_ACK with that write on MEM_*, first fetch read in the following slot.

Source files
------------

// File: rtl/fb_line_fetch_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_line_fetch_arbiter                                                     |
// | Shares the single-port framebuffer between next-line prefetch into a      |
// | ping-pong line buffer and a drawing-engine write port.                    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fb_line_fetch_arbiter #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 528,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 3,
    parameter int FAIR_N   = 8
) (
    input  logic              CLOCK_PIXEL,
    input  logic              RESET_N,
    input  logic              LINE_START,
    input  logic [9:0]        LINE_NUM,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_ACK,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              LB_WE,
    output logic [10:0]       LB_ADDR,
    output logic [DATA_W-1:0] LB_DATA,
    output logic              DISP_BANK,
    output logic              FETCH_BUSY,
    output logic              UNDERRUN,
    input  logic              CLR_UNDERRUN
);

    localparam int CNT_W = $clog2(FAIR_N + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              disp_bank_q, disp_bank_d;
    logic              fill_bank_q, fill_bank_d;
    logic              fetched_q, fetched_d;
    logic              underrun_q, underrun_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wr_ack_q, wr_ack_d;
    logic [10:0]       lb_pend_q, lb_pend_d;
    logic              lb_we_q, lb_we_d;
    logic [10:0]       lb_addr_q, lb_addr_d;

    logic              grant_wr;
    logic              grant_rd;
    logic              wr_ok;
    logic              in_fetch;
    logic              has_tgt;
    logic [10:0]       next_line;
    logic [9:0]        tgt_line;
    logic [ADDR_W-1:0] tgt_base;

    // Line V_TOTAL-1 is the last blanking line, so it prefetches line 0 of the next frame.
    assign next_line = {1'b0, LINE_NUM} + 11'd1;
    assign has_tgt   = (next_line < 11'(V_ACTIVE)) || (LINE_NUM == 10'(V_TOTAL - 1));
    assign tgt_line  = (LINE_NUM == 10'(V_TOTAL - 1)) ? 10'd0 : next_line[9:0];
    assign tgt_base  = ADDR_W'(tgt_line) * ADDR_W'(H_ACTIVE);
    assign in_fetch  = busy_q || (state_q == S_FETCH);
    assign wr_ok     = WR_REQ && !wr_ack_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        base_d      = base_q;
        rd_cnt_d    = rd_cnt_q;
        disp_bank_d = disp_bank_q;
        fill_bank_d = fill_bank_q;
        fetched_d   = fetched_q;
        underrun_d  = underrun_q;
        grant_wr    = 1'b0;
        grant_rd    = 1'b0;

        if (CLR_UNDERRUN) begin
            underrun_d = 1'b0;
        end

        if (LINE_START) begin
            // The line-start slot never reads: any old fetch is dropped, the new one begins next slot.
            grant_wr  = wr_ok;
            if (in_fetch) begin
                underrun_d = 1'b1;
            end
            if (in_fetch || fetched_q) begin
                disp_bank_d = fill_bank_q;
                fill_bank_d = ~fill_bank_q;
            end
            fetched_d = 1'b0;
            x_d       = '0;
            rd_cnt_d  = '0;
            base_d    = tgt_base;
            state_d   = has_tgt ? S_FETCH : S_IDLE;
        end else if (state_q == S_IDLE) begin
            grant_wr = wr_ok;
        end else if (wr_ok && (rd_cnt_q == CNT_W'(FAIR_N))) begin
            grant_wr = 1'b1;
            rd_cnt_d = '0;
        end else begin
            grant_rd = 1'b1;
            x_d      = x_q + 10'd1;
            if (rd_cnt_q != CNT_W'(FAIR_N)) begin
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
            if (x_q == 10'(H_ACTIVE - 1)) begin
                state_d   = S_IDLE;
                fetched_d = 1'b1;
            end
        end

        mem_en_d    = grant_rd || grant_wr;
        mem_we_d    = grant_wr;
        wr_ack_d    = grant_wr;
        mem_wdata_d = grant_wr ? WR_DATA : '0;
        if (grant_wr) begin
            mem_addr_d = WR_ADDR;
        end else if (grant_rd) begin
            mem_addr_d = base_q + ADDR_W'(x_q);
        end else begin
            mem_addr_d = '0;
        end

        // Destination is captured at issue so a bank swap cannot redirect a read already in flight.
        lb_pend_d = grant_rd ? {fill_bank_q, x_q} : lb_pend_q;
        lb_we_d   = mem_en_q && !mem_we_q;
        lb_addr_d = lb_we_d ? lb_pend_q : '0;
        busy_d    = grant_rd || lb_we_d;
    end

    always_ff @(posedge CLOCK_PIXEL or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            base_q      <= '0;
            rd_cnt_q    <= '0;
            disp_bank_q <= 1'b0;
            fill_bank_q <= 1'b1;
            fetched_q   <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            lb_pend_q   <= '0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            base_q      <= base_d;
            rd_cnt_q    <= rd_cnt_d;
            disp_bank_q <= disp_bank_d;
            fill_bank_q <= fill_bank_d;
            fetched_q   <= fetched_d;
            underrun_q  <= underrun_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wr_ack_q    <= wr_ack_d;
            lb_pend_q   <= lb_pend_d;
            lb_we_q     <= lb_we_d;
            lb_addr_q   <= lb_addr_d;
        end
    end

    assign WR_ACK     = wr_ack_q;
    assign MEM_EN     = mem_en_q;
    assign MEM_WE     = mem_we_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_WDATA  = mem_wdata_q;
    assign LB_WE      = lb_we_q;
    assign LB_ADDR    = lb_addr_q;
    // RAM data only exists in the return cycle, so it passes straight through under the strobe.
    assign LB_DATA    = lb_we_q ? MEM_RDATA : '0;
    assign DISP_BANK  = disp_bank_q;
    assign FETCH_BUSY = busy_q;
    assign UNDERRUN   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_line_fetch_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fb_line_fetch_arbiter                                                  |
// | Directed scoreboard bench for the framebuffer line-fetch arbiter.         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_fb_line_fetch_arbiter;

    localparam int AW = 19;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          line_start = 1'b0;
    logic [9:0]    line_num = '0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clr_underrun = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic          wr_ack, mem_en, mem_we, lb_we, disp_bank, fetch_busy, underrun;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, lb_data;
    logic [10:0]   lb_addr;

    fb_line_fetch_arbiter dut (
        .CLOCK_PIXEL (clk),
        .RESET_N     (rst_n),
        .LINE_START  (line_start),
        .LINE_NUM    (line_num),
        .WR_REQ      (wr_req),
        .WR_ADDR     (wr_addr),
        .WR_DATA     (wr_data),
        .WR_ACK      (wr_ack),
        .MEM_EN      (mem_en),
        .MEM_WE      (mem_we),
        .MEM_ADDR    (mem_addr),
        .MEM_WDATA   (mem_wdata),
        .MEM_RDATA   (mem_rdata),
        .LB_WE       (lb_we),
        .LB_ADDR     (lb_addr),
        .LB_DATA     (lb_data),
        .DISP_BANK   (disp_bank),
        .FETCH_BUSY  (fetch_busy),
        .UNDERRUN    (underrun),
        .CLR_UNDERRUN(clr_underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
        return a[2:0] ^ a[5:3];
    endfunction

    // RAM model: read data for the command presented in a cycle appears in the next cycle.
    always @(posedge clk) mem_rdata <= ram_f(mem_addr);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_exp_t;

    typedef struct packed {
        logic [10:0]   lba;
        logic [AW-1:0] src;
    } lb_exp_t;

    mem_exp_t exp_mem[$];
    lb_exp_t  exp_lb[$];

    int n_checks = 0;
    int n_pass = 0;
    int busy_cnt = 0;
    int ack_busy = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_rd(input int addr, input logic bank, input int x, input bit with_lb);
        mem_exp_t e;
        lb_exp_t  l;
        e.we = 1'b0; e.addr = AW'(addr); e.data = '0;
        exp_mem.push_back(e);
        if (with_lb) begin
            l.lba = {bank, 10'(x)}; l.src = AW'(addr);
            exp_lb.push_back(l);
        end
    endtask

    task automatic push_wr(input int addr, input int data);
        mem_exp_t e;
        e.we = 1'b1; e.addr = AW'(addr); e.data = DW'(data);
        exp_mem.push_back(e);
    endtask

    task automatic pulse_line(input int n, input bit clr);
        @(negedge clk);
        line_start = 1'b1; line_num = 10'(n); clr_underrun = clr;
        @(negedge clk);
        line_start = 1'b0; clr_underrun = 1'b0;
    endtask

    task automatic write_burst(input int n, input int abase, input bit gap_chk);
        int last;
        int waited;
        last = 0;
        wr_req = 1'b1; wr_addr = AW'(abase); wr_data = DW'(0);
        for (int k = 0; k < n; k++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!wr_ack && waited < 2000);
            chk("wr_ack_arrives", longint'(wr_ack), 1);
            if (!wr_ack) break;
            if (gap_chk && k > 0) chk("wr_ack_gap", longint'(cyc - last), 2);
            last = cyc;
            wr_addr = AW'(abase + k + 1); wr_data = DW'(k + 1);
        end
        wr_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((exp_mem.size() != 0 || exp_lb.size() != 0 || fetch_busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(name, longint'(exp_mem.size() + exp_lb.size()), 0);
    endtask

    // Monitor: every command or line-buffer write must match the head of its queue.
    initial begin
        mem_exp_t em;
        lb_exp_t  el;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fetch_busy) busy_cnt++;
                if (wr_ack && fetch_busy) ack_busy++;
                if (wr_ack) chk("ack_with_write_cmd", longint'(mem_en && mem_we), 1);
                if (mem_en) begin
                    chk("mem_cmd_expected", longint'(exp_mem.size() > 0), 1);
                    if (exp_mem.size() > 0) begin
                        em = exp_mem.pop_front();
                        chk("mem_we", longint'(mem_we), longint'(em.we));
                        chk("mem_addr", longint'(mem_addr), longint'(em.addr));
                        if (em.we) chk("mem_wdata", longint'(mem_wdata), longint'(em.data));
                    end
                end
                if (lb_we) begin
                    chk("lb_we_expected", longint'(exp_lb.size() > 0), 1);
                    if (exp_lb.size() > 0) begin
                        el = exp_lb.pop_front();
                        chk("lb_addr", longint'(lb_addr), longint'(el.lba));
                        chk("lb_data", longint'(lb_data), longint'(ram_f(el.src)));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outputs", longint'({mem_en, mem_we, mem_addr, mem_wdata, wr_ack, lb_we,
                                        lb_addr, lb_data, disp_bank, fetch_busy, underrun}), 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Line 5 -> fetch line 6, no writer, fill bank 1
        for (int i = 0; i < 800; i++) push_rd(4800 + i, 1'b1, i, 1'b1);
        busy_cnt = 0;
        pulse_line(5, 1'b0);
        chk("disp_bank_first", longint'(disp_bank), 0);
        wait_idle("drain_fetch1");
        chk("busy_cycles_fetch1", longint'(busy_cnt), 801);
        chk("no_underrun_fetch1", longint'(underrun), 0);

        // Same fetch with a greedy writer: 8 reads then 1 write, bank swapped to 0
        for (int g = 0; g < 100; g++) begin
            for (int i = 0; i < 8; i++) push_rd(4800 + 8 * g + i, 1'b0, 8 * g + i, 1'b1);
            push_wr(32'h40000 + g, g);
        end
        busy_cnt = 0;
        ack_busy = 0;
        pulse_line(5, 1'b0);
        chk("disp_bank_swap1", longint'(disp_bank), 1);
        write_burst(100, 32'h40000, 1'b0);
        wait_idle("drain_fetch2");
        chk("acks_during_fetch", longint'(ack_busy), 100);
        chk("busy_cycles_fetch2", longint'(busy_cnt), 900);
        chk("busy_within_bound", longint'(busy_cnt <= 901), 1);

        // Last frame line -> fetch line 0
        for (int i = 0; i < 800; i++) push_rd(i, 1'b1, i, 1'b1);
        pulse_line(527, 1'b0);
        chk("disp_bank_swap2", longint'(disp_bank), 0);
        wait_idle("drain_line0");

        // Last visible line: no fetch, writer alternates
        for (int k = 0; k < 6; k++) push_wr(32'h50000 + k, k);
        pulse_line(479, 1'b0);
        chk("disp_bank_swap3", longint'(disp_bank), 1);
        write_burst(6, 32'h50000, 1'b1);
        wait_idle("drain_479");

        // Blanking line with no completed fetch: bank held
        pulse_line(500, 1'b0);
        chk("disp_bank_held", longint'(disp_bank), 1);
        repeat (20) @(negedge clk);
        wait_idle("drain_500");

        // Underrun: new line start 500 cycles into a fetch, clear in the same cycle
        for (int i = 0; i < 499; i++) push_rd(8800 + i, 1'b0, i, 1'b1);
        for (int i = 0; i < 800; i++) push_rd(16800 + i, 1'b1, i, 1'b1);
        pulse_line(10, 1'b0);
        chk("disp_bank_no_swap", longint'(disp_bank), 1);
        repeat (498) @(negedge clk);
        pulse_line(20, 1'b1);
        chk("underrun_set_wins", longint'(underrun), 1);
        chk("disp_bank_underrun", longint'(disp_bank), 0);
        wait_idle("drain_underrun");
        chk("underrun_sticky", longint'(underrun), 1);
        @(negedge clk); clr_underrun = 1'b1;
        @(negedge clk); clr_underrun = 1'b0;
        chk("underrun_cleared", longint'(underrun), 0);

        // Asynchronous reset 300 cycles into a fetch of line 101
        for (int i = 0; i < 299; i++) push_rd(80800 + i, 1'b0, i, i < 298);
        pulse_line(100, 1'b0);
        chk("disp_bank_swap4", longint'(disp_bank), 1);
        repeat (299) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", longint'({mem_en, mem_we, mem_addr, mem_wdata, wr_ack, lb_we,
                                             lb_addr, lb_data, disp_bank, fetch_busy, underrun}), 0);
        chk("reset_queue_consumed", longint'(exp_mem.size() + exp_lb.size()), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("quiet_after_reset", longint'({mem_en, lb_we, fetch_busy}), 0);

        // Write and line start together in idle: write first, then fetch of line 1
        push_wr(32'h7abcd, 5);
        for (int i = 0; i < 800; i++) push_rd(800 + i, 1'b1, i, 1'b1);
        @(negedge clk);
        line_start = 1'b1; line_num = 10'd0;
        wr_req = 1'b1; wr_addr = 19'h7abcd; wr_data = 3'd5;
        @(negedge clk);
        line_start = 1'b0;
        chk("simul_wr_ack", longint'(wr_ack), 1);
        wr_req = 1'b0;
        @(negedge clk);
        chk("first_read_next_slot", longint'(mem_en && !mem_we), 1);
        chk("disp_bank_after_reset", longint'(disp_bank), 0);
        wait_idle("drain_simul");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
